// File: rtl/mvau_weight_stream_if.sv
// Weight-word stream from the weight sequencer to the MVAU compute stage.
// A beat transfers on a rising clock edge where tvalid and tready are both high; while tvalid is
// high and tready low the producer holds tdata/tlast stable and keeps tvalid asserted.
interface mvau_weight_stream_if #(
  parameter int DW = 2
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/mvau_weight_stream.sv
// Read-side sequencer for the MVAU weight memory: walks the address space NUM_REPS times per start
// and re-times the 1-cycle memory read latency through a 2-entry FIFO onto a backpressured stream.
module mvau_weight_stream #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4,
  parameter int NUM_REPS     = 2
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    start,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic                    wmem_rd,
  input  logic [SIMD*TW-1:0]      wmem_out,
  mvau_weight_stream_if.master    out,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state_o,
  output logic [1:0]              dbg_fifo_count_o
);

  localparam int DW     = SIMD * TW;
  localparam int REP_BW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [REP_BW-1:0]       LAST_REP  = REP_BW'(NUM_REPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
  logic [REP_BW-1:0]       rep_q, rep_d;
  logic                    done_q, done_d;
  logic                    inflight_q, inflight_last_q;

  logic [DW-1:0] fifo_data_q [2];
  logic          fifo_last_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;

  logic       issue;
  logic       pop;
  logic       push;
  logic [2:0] occ;

  // Occupancy after this cycle: stored words plus the read in flight, minus the word leaving now.
  assign pop  = (count_q != 2'd0) && out.tready;
  assign push = inflight_q;
  assign occ  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        issue = (occ < 3'd2);
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (rep_q == LAST_REP) begin
              rep_d   = '0;
              state_d = S_DRAIN;
            end else begin
              rep_d = rep_q + REP_BW'(1);
            end
          end else begin
            addr_d = addr_q + WMEM_ADDR_BW'(1);
          end
        end
      end
      S_DRAIN: begin
        if ((count_q == 2'd0) && !inflight_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      rep_q           <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '{default: '0};
      fifo_last_q     <= '{default: 1'b0};
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rep_q           <= rep_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (addr_q == LAST_ADDR);
      if (push) begin
        fifo_data_q[wr_ptr_q] <= wmem_out;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign wmem_addr        = addr_q;
  assign wmem_rd          = issue;
  assign out.tvalid       = (count_q != 2'd0);
  assign out.tdata        = out.tvalid ? fifo_data_q[rd_ptr_q] : '0;
  assign out.tlast        = out.tvalid ? fifo_last_q[rd_ptr_q] : 1'b0;
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign dbg_state_o      = state_q;
  assign dbg_fifo_count_o = count_q;

endmodule
